// File: rtl/pipeline_sched.sv
// Hazard scheduler for the 5-stage pipeline: per-stage stall/flush controls,
// the multi-cycle mul/div sequencer and the pending-redirect tracker.
module pipeline_sched #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] d_ra1,
  input  logic [4:0] d_ra2,
  input  logic       e_memread,
  input  logic [4:0] e_dst,
  input  logic       e_branch_taken,
  input  logic       e_muldiv_start,
  input  logic       e_is_div,
  input  logic       ibus_stall,
  input  logic       dbus_stall,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic             md_start;
  logic             load_use;
  logic [CNT_W-1:0] ld_val;

  assign md_start = (state_q == S_IDLE) && e_muldiv_start;
  assign ld_val   = e_is_div ? DIV_LD : MUL_LD;
  assign load_use = e_memread && (e_dst != 5'd0) &&
                    ((e_dst == d_ra1) || (e_dst == d_ra2));

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (!dbus_stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (e_muldiv_start) begin
            cnt_d = ld_val;
            // A 2-cycle op has no BUSY cycles: start, then straight to DONE.
            state_d = (ld_val == '0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          // cnt_q is the number of BUSY cycles left, including this one.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (e_branch_taken && ibus_stall) begin
        pend_d = 1'b1;
      end else if (!ibus_stall) begin
        pend_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (dbus_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else begin
      if (md_start || (state_q == S_BUSY)) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (e_branch_taken) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (ibus_stall) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
      // The stale wrong-path fetch must be dropped whenever it finally lands.
      if (pend_q) flush_d = 1'b1;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign stallF      = resetn & stall_f;
  assign stallD      = resetn & stall_d;
  assign stallE      = resetn & stall_e;
  assign stallM      = resetn & stall_m;
  assign flushD      = resetn & flush_d;
  assign flushE      = resetn & flush_e;
  assign flushM      = resetn & flush_m;
  assign muldiv_busy = resetn & (state_q == S_BUSY);
  assign muldiv_done = resetn & (state_q == S_DONE);

endmodule

// File: tb/tb_pipeline_sched.sv
// Self-checking bench for pipeline_sched: directed test-plan scenarios plus
// randomized traffic against a cycle-occupancy reference model.
module tb_pipeline_sched;

  localparam int MUL_N = 3;
  localparam int DIV_N = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] d_ra1, d_ra2, e_dst;
  logic       e_memread, e_branch_taken, e_muldiv_start, e_is_div;
  logic       ibus_stall, dbus_stall;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, muldiv_busy, muldiv_done;

  always #5 clk = ~clk;

  pipeline_sched #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .d_ra1(d_ra1), .d_ra2(d_ra2), .e_memread(e_memread), .e_dst(e_dst),
    .e_branch_taken(e_branch_taken), .e_muldiv_start(e_muldiv_start),
    .e_is_div(e_is_div), .ibus_stall(ibus_stall), .dbus_stall(dbus_stall),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  typedef struct {
    logic [4:0] ra1, ra2, dst;
    logic       memread, br, start, isdiv, ibus, dbus;
  } in_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycles still to go in the current mul/div op
  // (0 = none, 1 = the result cycle) and the pending-redirect flag.
  int   m_left = 0;
  logic m_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] dut_outs();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushM, muldiv_busy, muldiv_done};
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v.ra1 = 0; v.ra2 = 0; v.dst = 0;
    v.memread = 0; v.br = 0; v.start = 0; v.isdiv = 0; v.ibus = 0; v.dbus = 0;
    return v;
  endfunction

  // Expected {sF,sD,sE,sM,fD,fE,fM,busy,done} from the priority rules.
  function automatic logic [8:0] model_outs(input in_t v);
    logic sf, sd, se, sm, fd, fe, fm, st, bz, dn, lu;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0;
    if (!resetn) return 9'd0;
    st = (m_left == 0) && v.start;
    bz = (m_left > 1);
    dn = (m_left == 1);
    lu = v.memread && (v.dst != 0) && (v.dst == v.ra1 || v.dst == v.ra2);
    if (v.dbus) begin
      sf = 1; sd = 1; se = 1; sm = 1;
    end else begin
      if (st || bz) begin sf = 1; sd = 1; se = 1; fm = 1; end
      else if (v.br) begin fd = 1; fe = 1; end
      else if (lu)   begin sf = 1; sd = 1; fe = 1; end
      else if (v.ibus) begin sf = 1; fd = 1; end
      if (m_pend) fd = 1;
    end
    return {sf, sd, se, sm, fd, fe, fm, bz, dn};
  endfunction

  task automatic model_step(input in_t v);
    if (!resetn) begin
      m_left = 0;
      m_pend = 0;
    end else if (!v.dbus) begin
      if (m_left == 0 && v.start) m_left = (v.isdiv ? DIV_N : MUL_N) - 1;
      else if (m_left > 0)        m_left--;
      if (v.br && v.ibus) m_pend = 1;
      else if (!v.ibus)   m_pend = 0;
    end
  endtask

  task automatic drive(input in_t v);
    d_ra1 = v.ra1; d_ra2 = v.ra2; e_dst = v.dst; e_memread = v.memread;
    e_branch_taken = v.br; e_muldiv_start = v.start; e_is_div = v.isdiv;
    ibus_stall = v.ibus; dbus_stall = v.dbus;
  endtask

  // One clock cycle: drive after the falling edge, check mid-cycle, advance model at the rising edge.
  task automatic tick(input in_t v, input string tag, output logic [8:0] o);
    @(negedge clk);
    drive(v);
    #2;
    o = dut_outs();
    check(tag, o, model_outs(v));
    @(posedge clk);
    model_step(v);
  endtask

  // Idle cycles until muldiv_done is seen; returns cycles after the start cycle, or -1.
  task automatic wait_done(input int start_t, input int limit, output int at);
    logic [8:0] o;
    in_t v;
    v = idle_in();
    at = -1;
    for (int c = start_t; c < limit; c++) begin
      v.dbus = (c >= 4 && c <= 7 && limit > 20);
      tick(v, "wait_done", o);
      if (o[0] && at < 0) begin
        at = c;
        break;
      end
    end
  endtask

  initial begin
    in_t v;
    logic [8:0] o;
    int at;

    resetn = 1'b0;
    drive(idle_in());

    // Reset: outputs low even with hazard-causing inputs applied.
    v = idle_in(); v.dbus = 1; v.start = 1;
    tick(v, "reset_dbus", o);
    check("reset_zero", o, 9'd0);
    #1 resetn = 1'b1;
    tick(idle_in(), "post_reset", o);
    check("post_reset_zero", o, 9'd0);

    // Load-use hazards.
    v = idle_in(); v.memread = 1; v.dst = 5; v.ra2 = 5; v.ra1 = 3;
    tick(v, "load_use", o);
    check("load_use_const", o, 9'b110001000);
    v = idle_in(); v.memread = 1; v.dst = 0; v.ra1 = 0;
    tick(v, "load_use_x0", o);
    check("load_use_x0_const", o, 9'd0);

    // Multiply: start at t, done at t+2, idle at t+3.
    v = idle_in(); v.start = 1;
    tick(v, "mul_start", o);
    check("mul_start_const", o, 9'b111000100);
    wait_done(1, 10, at);
    check("mul_done_cycle", at, 2);
    tick(idle_in(), "mul_idle", o);
    check("mul_idle_const", o, 9'd0);

    // Divide with a 4-cycle dbus stall inside BUSY: done slides from t+15 to t+19.
    v = idle_in(); v.start = 1; v.isdiv = 1;
    tick(v, "div_start", o);
    wait_done(1, 40, at);
    check("div_done_cycle", at, 19);
    tick(idle_in(), "div_idle", o);

    // Taken branch while fetch waits 3 more cycles: flushD on 5 cycles, then clear.
    v = idle_in(); v.br = 1; v.ibus = 1;
    tick(v, "br_ibus", o);
    check("br_flushD_0", o[4], 1'b1);
    for (int c = 1; c <= 3; c++) begin
      v = idle_in(); v.ibus = 1;
      tick(v, "br_wait", o);
      check("br_flushD_wait", o[4], 1'b1);
    end
    tick(idle_in(), "br_land", o);
    check("br_flushD_land", o[4], 1'b1);
    tick(idle_in(), "br_clear", o);
    check("br_flushD_clear", o[4], 1'b0);

    // Branch beats a simultaneous load-use.
    v = idle_in(); v.br = 1; v.memread = 1; v.dst = 7; v.ra1 = 7;
    tick(v, "br_lu", o);
    check("br_lu_const", o, 9'b000011000);

    // Asynchronous reset mid-BUSY.
    v = idle_in(); v.start = 1; v.isdiv = 1;
    tick(v, "rst_div_start", o);
    tick(idle_in(), "rst_div_busy", o);
    #2 resetn = 1'b0;
    #1 check("async_reset_zero", dut_outs(), 9'd0);
    tick(idle_in(), "in_reset", o);
    check("in_reset_no_done", o, 9'd0);
    #1 resetn = 1'b1;
    v = idle_in(); v.start = 1;
    tick(v, "rst_restart", o);
    check("rst_restart_const", o, 9'b111000100);
    wait_done(1, 10, at);
    check("rst_restart_done", at, 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      v.ra1     = 5'($urandom_range(0, 7));
      v.ra2     = 5'($urandom_range(0, 7));
      v.dst     = 5'($urandom_range(0, 7));
      v.memread = 1'($urandom_range(0, 1));
      v.br      = ($urandom_range(0, 7) == 0);
      v.start   = ($urandom_range(0, 5) == 0);
      v.isdiv   = ($urandom_range(0, 3) == 0);
      v.ibus    = ($urandom_range(0, 3) == 0);
      v.dbus    = ($urandom_range(0, 7) == 0);
      tick(v, "random", o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sched.md
Name: pipeline_sched

Overview:
- Central hazard scheduler for the 5-stage RV64 pipeline (F/D/E/M/W).
- Consumes decode-stage source register addresses, execute-stage state and bus wait signals.
- Produces per-stage stall and flush (bubble) controls for the F→D, D→E and E→M pipeline registers.
- Sequences the multi-cycle mul/div unit in Execute and tracks a branch redirect that lands while fetch is still waiting on the instruction bus.

Parameters:
- MUL_CYCLES, 3, total Execute-stage occupancy of a multiply (≥2).
- DIV_CYCLES, 16, total Execute-stage occupancy of a divide/remainder (≥2).
- CNT_W, 5, muldiv counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- d_ra1  in  5  rs1 address of the instruction in Decode
- d_ra2  in  5  rs2 address of the instruction in Decode
- e_memread  in  1  instruction in Execute is a load
- e_dst  in  5  destination register of the instruction in Execute
- e_branch_taken  in  1  Execute resolved a taken branch or jump (redirect)
- e_muldiv_start  in  1  instruction in Execute is mul/div and has not started
- e_is_div  in  1  qualifies e_muldiv_start: 1 = divide, 0 = multiply
- ibus_stall  in  1  fetch is waiting for the instruction bus
- dbus_stall  in  1  Memory stage is waiting for the data bus
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register
- flushD, flushE, flushM  out  1 each  load a bubble into the F→D, D→E and E→M registers
- muldiv_busy  out  1  FSM is in BUSY
- muldiv_done  out  1  one-cycle pulse: mul/div result valid in Execute this cycle

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (resetn).
  - While resetn=0, the FSM is in IDLE, the counter is 0, pend_flush=0, and every output is 0.
  - Reset asserted mid-operation abandons the mul/div with no done pulse.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when e_muldiv_start=1 and dbus_stall=0. The counter loads (e_is_div ? DIV_CYCLES : MUL_CYCLES) − 2.
  - BUSY: the counter decrements each cycle in which dbus_stall=0. At counter 0 with dbus_stall=0, go to DONE.
  - DONE: muldiv_done=1, then IDLE on the next cycle (DONE is held while dbus_stall=1).
  - e_muldiv_start is ignored outside IDLE. An N-cycle op occupies Execute for exactly N cycles (start cycle + N−2 BUSY cycles + DONE) when there is no dbus_stall.
- Output priority, highest first, evaluated combinationally each cycle:
  1. dbus_stall=1: stallF=stallD=stallE=stallM=1; all flushes 0; FSM and counter frozen.
  2. FSM start cycle or BUSY: stallF=stallD=stallE=1, flushM=1 (bubble into M); stallM=0; other flushes 0.
  3. e_branch_taken=1: flushD=1, flushE=1; no stalls. Any load-use hazard on the wrong-path Decode instruction is discarded.
  4. Load-use: e_memread=1, e_dst≠0, and (e_dst==d_ra1 or e_dst==d_ra2) gives stallF=stallD=1, flushE=1.
  5. ibus_stall=1: stallF=1, flushD=1.
  6. Otherwise all stall and flush outputs are 0.
- Pending redirect (pend_flush register):
  - Set when e_branch_taken=1, ibus_stall=1 and dbus_stall=0.
  - Cleared on the first cycle with ibus_stall=0; flushD is forced to 1 in that cycle so the stale wrong-path fetch is dropped.
  - While set, flushD=1 whenever priority 1 is not active.
  - A new taken branch while already set keeps it set.
- DONE cycle: no stalls from the FSM; lower priorities (3–5) apply normally.
- x0 never creates a load-use hazard. d_ra1/d_ra2 are compared even when the instruction does not use that operand; a spurious stall is acceptable.
- No registered datapath values. Only the FSM, the counter and pend_flush are state.

Test Plan:
- Load-use: e_memread=1, e_dst=5, d_ra2=5 for 1 cycle → stallF=stallD=flushE=1 that cycle. With e_dst=0 and d_ra1=0 → all outputs 0.
- MUL_CYCLES=3: e_muldiv_start=1, e_is_div=0 at cycle t:
  - t and t+1 → stallF/D/E=1, flushM=1.
  - muldiv_busy=1 at t+1 only.
  - muldiv_done=1 at t+2 with stalls 0.
  - IDLE at t+3.
- Divide (DIV_CYCLES=16) with dbus_stall=1 for 4 cycles mid-BUSY → muldiv_done arrives 4 cycles later (cycle t+19). All four stalls are 1 and all flushes 0 during the dbus_stall window.
- e_branch_taken=1 with ibus_stall=1 for 3 further cycles → flushD=1 on all 4 cycles plus the first ibus_stall=0 cycle; pend_flush clears afterwards.
- Branch and load-use asserted together → flushD=flushE=1, stallF=stallD=0.
- resetn pulsed low during BUSY → outputs 0 immediately (asynchronous), no muldiv_done; after release the FSM is in IDLE and accepts a new start.
